// File: rtl/mult_result_acc.sv
// mult_result_acc: sums NACC unsigned multiplier products per frame and
// hands each frame total downstream through a valid/ready handshake.
// The beat that completes a pending frame's handshake may open the next
// frame in the same cycle, so a continuous stream runs without bubbles.
// Optional build macro: MULT_RESULT_ACC_SATURATE_EN clamps the sum at
// 2^ACCW-1 on carry-out instead of wrapping.
module mult_result_acc #(
  parameter int WIDTHP = 40,
  parameter int ACCW   = 42,
  parameter int NACC   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTHP-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACCW-1:0]   out_data,
  output logic              out_ovf,
  output logic              err_drop
);

  typedef enum logic {
    ACC  = 1'b0,
    FULL = 1'b1
  } state_e;

  localparam logic [7:0] LastBeat = 8'(NACC - 1);

  state_e            state_q, state_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              errDrop_q, errDrop_d;

  logic              beatAccept;
  logic              outHandshake;
  logic [ACCW:0]     inExt;
  logic [ACCW:0]     sumExt;
  logic              addCarry;
  logic [ACCW-1:0]   addResult;

  // Handshake qualifiers; in_ready is combinational from out_ready so a
  // draining frame can accept the first beat of the next one.
  always_comb begin
    in_ready     = (state_q == ACC) | out_ready;
    out_valid    = (state_q == FULL);
    beatAccept   = in_valid & in_ready;
    outHandshake = out_valid & out_ready;
    out_data     = acc_q;
    out_ovf      = ovf_q;
    err_drop     = errDrop_q;
  end

  // Zero-extend the product and form the ACCW-bit sum with its carry-out;
  // the extra top bit of the sum is the carry.
  always_comb begin
    inExt               = '0;
    inExt[WIDTHP-1:0]   = in_data;
    sumExt              = {1'b0, acc_q} + inExt;
    addCarry            = sumExt[ACCW];
`ifdef MULT_RESULT_ACC_SATURATE_EN
    addResult           = addCarry ? {ACCW{1'b1}} : sumExt[ACCW-1:0];
`else
    addResult           = sumExt[ACCW-1:0];
`endif
  end

  // Next-state logic: accumulate in ACC, hold in FULL until the sum is
  // taken, then either clear or restart the frame with a coincident beat.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    errDrop_d = errDrop_q | (in_valid & ~in_ready);
    unique case (state_q)
      ACC: begin
        if (beatAccept) begin
          acc_d = addResult;
          cnt_d = cnt_q + 8'd1;
          ovf_d = ovf_q | addCarry;
          if (cnt_q == LastBeat) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (outHandshake) begin
          state_d = ACC;
          ovf_d   = 1'b0;
          if (beatAccept) begin
            acc_d = inExt[ACCW-1:0];
            cnt_d = 8'd1;
          end else begin
            acc_d = '0;
            cnt_d = 8'd0;
          end
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  // State registers with synchronous reset that overrides any beat or
  // handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      errDrop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      errDrop_q <= errDrop_d;
    end
  end

endmodule

// File: tb/tb_mult_result_acc.sv
// tb_mult_result_acc: directed, table-driven bench for mult_result_acc
// with hand-written sequences for backpressure, back-to-back frames and
// mid-frame reset.
module tb_mult_result_acc;

  localparam int WIDTHP = 40;
  localparam int ACCW   = 42;
  localparam int NACC   = 16;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [WIDTHP-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [ACCW-1:0]   out_data;
  logic              out_ovf;
  logic              err_drop;

  int assertCount;
  int failCount;

  typedef struct {
    logic [WIDTHP-1:0] value;
    int                gapMax;
    logic [ACCW-1:0]   expData;
    logic              expOvf;
  } vec_t;

  vec_t vecs[6];

  mult_result_acc #(
    .WIDTHP(WIDTHP),
    .ACCW  (ACCW),
    .NACC  (NACC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .err_drop (err_drop)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Feed NACC beats of one value with random idle gaps, checking latency
  // and the frame result right after the last beat
  task automatic applyStimulus(input logic [WIDTHP-1:0] value, input int gapMax,
                               input logic readyDuring, input logic [ACCW-1:0] expData,
                               input logic expOvf, input string name);
    out_ready = readyDuring;
    for (int i = 0; i < NACC; i++) begin
      int gaps;
      gaps = $urandom_range(0, gapMax);
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        stepClk();
      end
      in_valid = 1'b1;
      in_data  = value;
      stepClk();
      in_valid = 1'b0;
      if (i == NACC - 2) checkOutput({name, " early_valid"}, 64'(out_valid), 64'd0);
    end
    checkOutput({name, " valid"}, 64'(out_valid), 64'd1);
    checkOutput({name, " data"}, 64'(out_data), 64'(expData));
    checkOutput({name, " ovf"}, 64'(out_ovf), 64'(expOvf));
  endtask

  // Take the pending sum with no new beat and confirm the block is idle
  task automatic drainFrame(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stepClk();
    checkOutput({name, " drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;

    vecs[0] = '{value: 40'd50,            gapMax: 0, expData: 42'd800,    expOvf: 1'b0};
    vecs[1] = '{value: 40'd32385,         gapMax: 3, expData: 42'd518160, expOvf: 1'b0};
    vecs[2] = '{value: 40'd0,             gapMax: 1, expData: 42'd0,      expOvf: 1'b0};
    vecs[3] = '{value: 40'h3F_FFFF_FFFF,  gapMax: 0, expData: 42'h3FF_FFFF_FFF0, expOvf: 1'b0};
`ifdef MULT_RESULT_ACC_SATURATE_EN
    vecs[4] = '{value: 40'hFF_FEFF_0001,  gapMax: 0, expData: 42'h3FF_FFFF_FFFF, expOvf: 1'b1};
    vecs[5] = '{value: 40'h40_0000_0000,  gapMax: 2, expData: 42'h3FF_FFFF_FFFF, expOvf: 1'b1};
`else
    vecs[4] = '{value: 40'hFF_FEFF_0001,  gapMax: 0, expData: 42'h3FF_EFF0_0010, expOvf: 1'b1};
    vecs[5] = '{value: 40'h40_0000_0000,  gapMax: 2, expData: 42'h000_0000_0000, expOvf: 1'b1};
`endif

    stepClk();
    stepClk();
    rst = 1'b0;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset out_data", 64'(out_data), 64'd0);
    checkOutput("reset out_ovf", 64'(out_ovf), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset err_drop", 64'(err_drop), 64'd0);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].value, vecs[v].gapMax, 1'b1, vecs[v].expData,
                    vecs[v].expOvf, $sformatf("vec%0d", v));
      drainFrame($sformatf("vec%0d", v));
    end

    // Backpressure: completed frame held while upstream keeps pushing
    applyStimulus(40'd7, 0, 1'b0, 42'd112, 1'b0, "bp");
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 40'd99;
      #1;
      checkOutput("bp in_ready", 64'(in_ready), 64'd0);
      stepClk();
      checkOutput("bp data_stable", 64'(out_data), 64'd112);
      checkOutput("bp valid_held", 64'(out_valid), 64'd1);
      checkOutput("bp err_drop", 64'(err_drop), 64'd1);
    end
    drainFrame("bp");
    applyStimulus(40'd3, 1, 1'b1, 42'd48, 1'b0, "bp_next");
    drainFrame("bp_next");
    checkOutput("bp err_sticky", 64'(err_drop), 64'd1);

    // Back-to-back frames with no bubble between them
    out_ready = 1'b1;
    for (int i = 0; i < 2 * NACC; i++) begin
      in_valid = 1'b1;
      in_data  = (i < NACC) ? 40'd1 : 40'd2;
      #1;
      if (i == NACC) checkOutput("b2b ready_in_full", 64'(in_ready), 64'd1);
      stepClk();
      if (i == NACC - 1) begin
        checkOutput("b2b f1_valid", 64'(out_valid), 64'd1);
        checkOutput("b2b f1_data", 64'(out_data), 64'd16);
      end
      if (i == NACC) checkOutput("b2b f2_started", 64'(out_valid), 64'd0);
      if (i == 2 * NACC - 1) begin
        checkOutput("b2b f2_valid", 64'(out_valid), 64'd1);
        checkOutput("b2b f2_data", 64'(out_data), 64'd32);
      end
    end
    drainFrame("b2b");

    // Reset mid-frame with a beat on the reset cycle, then a clean frame
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 40'd5;
      stepClk();
    end
    rst = 1'b1;
    stepClk();
    rst      = 1'b0;
    in_valid = 1'b0;
    checkOutput("rst_mid out_data", 64'(out_data), 64'd0);
    checkOutput("rst_mid err_drop", 64'(err_drop), 64'd0);
    applyStimulus(40'd1, 0, 1'b1, 42'd16, 1'b0, "rst_mid");
    checkOutput("rst_mid err_after", 64'(err_drop), 64'd0);
    drainFrame("rst_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
